// File: rtl/dmem_responder.sv
// Data-bus responder for the MIPS core: word load/store with a fixed wait-state latency,
// plus a sticky completion register that software writes at DONE_ADDR.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] DONE_ADDR   = 32'd84
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic        done,
    output logic [31:0] result
);
    localparam int         IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
    localparam logic       LAT_1  = (LATENCY == 32'sd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_r;
    logic [3:0]        cnt_r;
    logic              cap_we_r;
    logic [31:0]       cap_addr_r;
    logic [31:0]       cap_wdata_r;
    logic              ready_r;
    logic              err_r;
    logic              done_r;
    logic [31:0]       rdata_r;
    logic [31:0]       result_r;
    logic [31:0]       ram_r [DEPTH_WORDS];

    logic              commit_s;
    logic              eff_we_s;
    logic [31:0]       eff_addr_s;
    logic [31:0]       eff_wdata_s;
    logic              is_done_s;
    logic              is_ram_s;
    logic [IDX_W-1:0]  idx_s;
    logic              ram_we_s;

    // Select the request being completed and decide whether this edge enters RESP.
    // With LATENCY==1 the completing request is the one on the live inputs.
    always_comb begin
        eff_we_s    = cap_we_r;
        eff_addr_s  = cap_addr_r;
        eff_wdata_s = cap_wdata_r;
        commit_s    = 1'b0;
        case (state_r)
            IDLE: begin
                eff_we_s    = we;
                eff_addr_s  = addr;
                eff_wdata_s = wdata;
                commit_s    = req & LAT_1;
            end
            WAIT:    commit_s = (cnt_r <= 4'd1);
            RESP:    commit_s = 1'b0;
            default: commit_s = 1'b0;
        endcase
        is_done_s = (eff_addr_s == DONE_ADDR);
        is_ram_s  = !is_done_s && (eff_addr_s[1:0] == 2'b00) &&
                    (eff_addr_s[31:2] < 30'(DEPTH_WORDS));
        idx_s     = eff_addr_s[IDX_W+1:2];
        // Reset gating keeps a LATENCY==1 request from writing while reset is held.
        ram_we_s  = reset & commit_s & is_ram_s & eff_we_s;
    end

    // Request FSM, latency counter, completion register and registered response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            cap_we_r    <= 1'b0;
            cap_addr_r  <= 32'd0;
            cap_wdata_r <= 32'd0;
            ready_r     <= 1'b0;
            err_r       <= 1'b0;
            rdata_r     <= 32'd0;
            done_r      <= 1'b0;
            result_r    <= 32'd0;
        end else begin
            ready_r <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'd0;
            case (state_r)
                IDLE: begin
                    if (req) begin
                        cap_we_r    <= we;
                        cap_addr_r  <= addr;
                        cap_wdata_r <= wdata;
                        cnt_r       <= LAT_M1;
                        state_r     <= LAT_1 ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_r <= 4'd1) begin
                        state_r <= RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
            if (commit_s) begin
                ready_r <= 1'b1;
                if (is_done_s) begin
                    if (eff_we_s) begin
                        done_r   <= 1'b1;
                        result_r <= eff_wdata_s;
                    end else begin
                        rdata_r <= result_r;
                    end
                end else if (is_ram_s) begin
                    if (!eff_we_s) begin
                        rdata_r <= ram_r[idx_s];
                    end
                end else begin
                    err_r <= 1'b1;
                end
            end
        end
    end

    // Backing RAM; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[idx_s] <= eff_wdata_s;
        end
    end

    assign ready  = ready_r;
    assign rdata  = rdata_r;
    assign err    = err_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: five instances at different latencies, a per-cycle reference
// model built from the access rules, and directed plus randomized transactions.
`timescale 1ns/1ps
module tb_dmem_responder;
    localparam int NI = 5;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            3:       return 4;
            default: return 15;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a   [NI];
    logic        we_a    [NI];
    logic [31:0] addr_a  [NI];
    logic [31:0] wdata_a [NI];
    logic        ready_a [NI];
    logic        err_a   [NI];
    logic        done_a  [NI];
    logic [31:0] rdata_a [NI];
    logic [31:0] result_a[NI];
    bit          chk_en = 1'b0;
    int          n_chk  = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(.DEPTH_WORDS(64), .LATENCY(lat_of(g)), .DONE_ADDR(32'd84)) u_dut (
            .clk(clk), .reset(rst), .req(req_a[g]), .we(we_a[g]), .addr(addr_a[g]),
            .wdata(wdata_a[g]), .ready(ready_a[g]), .rdata(rdata_a[g]), .err(err_a[g]),
            .done(done_a[g]), .result(result_a[g])
        );
    end

    task automatic check(input string name, input int k, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s inst%0d (LATENCY=%0d) t=%0t got=%h expected=%h",
                      name, k, lat_of(k), $time, got, exp);
    endtask

    // Reference model: each request is serviced LATENCY cycles after acceptance; the
    // next request can be accepted two edges after the response edge.
    logic [31:0] m_ram    [NI][64];
    logic        m_ready  [NI];
    logic        m_err    [NI];
    logic        m_done   [NI];
    logic [31:0] m_rdata  [NI];
    logic [31:0] m_result [NI];
    bit          m_busy   [NI];
    longint      m_due    [NI];
    longint      m_free   [NI];
    logic        m_cwe    [NI];
    logic [31:0] m_ca     [NI];
    logic [31:0] m_cd     [NI];
    longint      cyc = 0;

    initial begin : model
        for (int k = 0; k < NI; k++) begin
            m_ready[k] = 1'b0; m_err[k] = 1'b0; m_done[k] = 1'b0;
            m_rdata[k] = 32'd0; m_result[k] = 32'd0; m_busy[k] = 1'b0;
            m_due[k] = 0; m_free[k] = 0;
        end
        forever begin
            @(posedge clk or negedge rst);
            if (rst === 1'b1) cyc++;
            for (int k = 0; k < NI; k++) begin
                if (rst !== 1'b1) begin
                    m_ready[k] = 1'b0; m_err[k] = 1'b0; m_done[k] = 1'b0;
                    m_rdata[k] = 32'd0; m_result[k] = 32'd0;
                    m_busy[k] = 1'b0; m_free[k] = 0;
                end else begin
                    m_ready[k] = 1'b0; m_err[k] = 1'b0; m_rdata[k] = 32'd0;
                    if (!m_busy[k] && cyc >= m_free[k] && req_a[k] === 1'b1) begin
                        m_busy[k] = 1'b1;
                        m_cwe[k] = we_a[k]; m_ca[k] = addr_a[k]; m_cd[k] = wdata_a[k];
                        m_due[k] = cyc + lat_of(k) - 1;
                    end
                    if (m_busy[k] && cyc == m_due[k]) begin
                        m_busy[k]  = 1'b0;
                        m_free[k]  = cyc + 2;
                        m_ready[k] = 1'b1;
                        if (m_ca[k] == 32'd84) begin
                            if (m_cwe[k]) begin
                                m_done[k] = 1'b1; m_result[k] = m_cd[k];
                            end else m_rdata[k] = m_result[k];
                        end else if (m_ca[k] % 4 == 0 && m_ca[k] / 4 < 64) begin
                            if (m_cwe[k]) m_ram[k][m_ca[k] / 4] = m_cd[k];
                            else m_rdata[k] = m_ram[k][m_ca[k] / 4];
                        end else m_err[k] = 1'b1;
                    end
                end
            end
        end
    end

    // Compare every instance against the model on every falling edge.
    initial begin : cmp
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int k = 0; k < NI; k++) begin
                    check("ready",  k, 32'(ready_a[k]), 32'(m_ready[k]));
                    check("err",    k, 32'(err_a[k]),   32'(m_err[k]));
                    check("rdata",  k, rdata_a[k],      m_rdata[k]);
                    check("done",   k, 32'(done_a[k]),  32'(m_done[k]));
                    check("result", k, result_a[k],     m_result[k]);
                end
            end
        end
    end

    task automatic xact(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input bit drop, output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_a[k] = 1'b1; we_a[k] = w; addr_a[k] = a; wdata_a[k] = d;
        if (drop) begin
            @(posedge clk);
            #2;
            req_a[k] = 1'b0; we_a[k] = ~w; addr_a[k] = $urandom; wdata_a[k] = $urandom;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (ready_a[k] !== 1'b1 && lat < 40);
        rd = rdata_a[k];
        er = err_a[k];
        check("ready_within_bound", k, 32'(ready_a[k]), 32'd1);
        req_a[k] = 1'b0;
    endtask

    task automatic dx(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_er, input string name);
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(k, w, a, d, 1'b0, rd, er, lat);
        check({name, "_latency"}, k, 32'(lat), 32'(lat_of(k)));
        check({name, "_rdata"},   k, rd, exp_rd);
        check({name, "_err"},     k, 32'(er), 32'(exp_er));
    endtask

    task automatic run_inst(input int k);
        logic [31:0] rd;
        logic        er;
        int          lat, first, second, pulses, sel;
        logic [31:0] a;
        for (int i = 0; i < 64; i++)
            if (i != 21) xact(k, 1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i), 1'b0, rd, er, lat);
        dx(k, 1'b1, 32'h50, 32'h7, 32'h0, 1'b0, "store_ram");
        dx(k, 1'b0, 32'h50, 32'h0, 32'h7, 1'b0, "load_ram");
        check("done_before_store", k, 32'(done_a[k]), 32'd0);
        dx(k, 1'b1, 32'd84, 32'd7, 32'h0, 1'b0, "store_done");
        check("done_set", k, 32'(done_a[k]), 32'd1);
        check("result_7", k, result_a[k], 32'd7);
        dx(k, 1'b0, 32'd84, 32'd0, 32'd7, 1'b0, "load_done");
        dx(k, 1'b1, 32'd84, 32'd9, 32'h0, 1'b0, "store_done2");
        check("done_sticky", k, 32'(done_a[k]), 32'd1);
        check("result_9", k, result_a[k], 32'd9);
        dx(k, 1'b1, 32'h52, 32'h5, 32'h0, 1'b1, "misaligned");
        dx(k, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, "out_of_range");
        dx(k, 1'b0, 32'h50, 32'h0, 32'h7, 1'b0, "load_after_illegal");

        // req held high across two loads
        @(negedge clk);
        req_a[k] = 1'b1; we_a[k] = 1'b0; addr_a[k] = 32'h50;
        first = 0; second = 0; pulses = 0;
        for (int n = 1; n <= 2 * lat_of(k) + 2; n++) begin
            @(negedge clk);
            if (ready_a[k] === 1'b1) begin
                pulses++;
                if (first == 0) first = n;
                else if (second == 0) second = n;
            end
        end
        req_a[k] = 1'b0;
        check("b2b_first", k, 32'(first), 32'(lat_of(k)));
        check("b2b_gap", k, 32'(second - first), 32'(lat_of(k) + 1));
        check("b2b_pulses", k, 32'(pulses), 32'd2);

        if (lat_of(k) >= 2) begin
            @(negedge clk);
            req_a[k] = 1'b1; we_a[k] = 1'b1; addr_a[k] = 32'h10; wdata_a[k] = 32'hDEAD_BEEF;
            @(posedge clk);
            if (lat_of(k) >= 3) @(posedge clk);
            #2;
            rst = 1'b0;
            req_a[k] = 1'b0;
            #1;
            check("rst_ready",  k, 32'(ready_a[k]), 32'd0);
            check("rst_err",    k, 32'(err_a[k]),   32'd0);
            check("rst_rdata",  k, rdata_a[k],      32'd0);
            check("rst_done",   k, 32'(done_a[k]),  32'd0);
            check("rst_result", k, result_a[k],     32'd0);
            pulses = 0;
            repeat (2) begin
                @(negedge clk);
                if (ready_a[k] === 1'b1) pulses++;
            end
            rst = 1'b1;
            repeat (lat_of(k) + 2) begin
                @(negedge clk);
                if (ready_a[k] === 1'b1) pulses++;
            end
            check("rst_no_ready", k, 32'(pulses), 32'd0);
            dx(k, 1'b0, 32'h10, 32'h0, 32'h1000_0004, 1'b0, "rst_keep_ram");
        end

        for (int t = 0; t < 30; t++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, 63)) * 32'd4;
                6:       a = 32'd84;
                7:       a = 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(1, 3));
                8:       a = (32'd64 + 32'($urandom_range(0, 1000))) * 32'd4;
                default: a = $urandom;
            endcase
            xact(k, 1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 3) == 0), rd, er, lat);
        end
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin : drv
        rst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            req_a[k] = 1'b0; we_a[k] = 1'b0; addr_a[k] = 32'd0; wdata_a[k] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check("reset_ready",  k, 32'(ready_a[k]), 32'd0);
            check("reset_err",    k, 32'(err_a[k]),   32'd0);
            check("reset_rdata",  k, rdata_a[k],      32'd0);
            check("reset_done",   k, 32'(done_a[k]),  32'd0);
            check("reset_result", k, result_a[k],     32'd0);
        end
        rst = 1'b1;
        chk_en = 1'b1;
        for (int k = 0; k < NI; k++) run_inst(k);
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
